// File: rtl/soc_system_sysid_pkg.sv
// soc_system_sysid_pkg: shared states and constants for the system-ID checker
package soc_system_sysid_pkg;
    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'hACD5_1302;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h5592_5416;
    localparam int TMO_W = 16;
endpackage

// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker: reads system-ID and timestamp words and publishes a registered pass/fail/timeout verdict
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t state, next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0] lat_cnt;
    logic in_rd, lat_end, stall_out, cap_id, cap_ts, id_match;

    // Decode read phases, capture points and the stall abort for the current state
    always_comb begin
        in_rd = state == RD_ID || state == RD_TS;
        lat_end = lat_cnt == LAT_LAST;
        stall_out = in_rd && avm_waitrequest && tmo_cnt == TMO_LAST;
        cap_id = READ_LATENCY == 0 ? state == RD_ID && !avm_waitrequest : state == LAT_ID && lat_end;
        cap_ts = READ_LATENCY == 0 ? state == RD_TS && !avm_waitrequest : state == LAT_TS && lat_end;
        id_match = id_value == EXPECTED_ID;
    end

    // Next-state logic; a zero-latency slave skips the latency states
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = RD_ID;
            RD_ID:   next_state = stall_out ? DONE : avm_waitrequest ? RD_ID : READ_LATENCY == 0 ? RD_TS : LAT_ID;
            LAT_ID:  next_state = lat_end ? RD_TS : LAT_ID;
            RD_TS:   next_state = stall_out ? DONE : avm_waitrequest ? RD_TS : READ_LATENCY == 0 ? DONE : LAT_TS;
            LAT_TS:  next_state = lat_end ? DONE : LAT_TS;
            DONE:    next_state = start ? RD_ID : DONE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    // Registered bus outputs, counters, captured words and verdict
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avm_read <= 1'b0;
            avm_address <= 1'b0;
            busy <= 1'b1;
            done <= 1'b0;
            id_ok <= 1'b0;
            ts_ok <= 1'b0;
            pass <= 1'b0;
            timeout <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            tmo_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            avm_read <= next_state == RD_ID || next_state == RD_TS;
            avm_address <= next_state == RD_TS || next_state == LAT_TS;
            busy <= next_state != DONE;
            tmo_cnt <= next_state != state ? '0 : in_rd && avm_waitrequest ? tmo_cnt + TMO_W'(1) : tmo_cnt;
            lat_cnt <= (state == LAT_ID || state == LAT_TS) && !lat_end ? lat_cnt + 2'd1 : 2'd0;
            if (cap_id) id_value <= avm_readdata;
            if (cap_ts) ts_value <= avm_readdata;
            if (cap_ts) begin
                done <= 1'b1;
                id_ok <= id_match;
                ts_ok <= avm_readdata == EXPECTED_TS;
                pass <= id_match && (avm_readdata == EXPECTED_TS || !CHECK_TS);
            end else if (stall_out) begin
                done <= 1'b1;
                timeout <= 1'b1;
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
                pass <= 1'b0;
            end else if (state == DONE && start) begin
                done <= 1'b0;
                timeout <= 1'b0;
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
                pass <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// tb_soc_system_sysid_checker: scoreboard bench over two checker configurations sharing one slave scenario
module tb_soc_system_sysid_checker;
    import soc_system_sysid_pkg::*;

    typedef struct {
        int cyc;
        logic [31:0] id, ts;
        bit id_ok, ts_ok, pass, tmo;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic rd[2], adr[2], wr[2], busy[2], done[2], id_ok[2], ts_ok[2], pass[2], tmo[2];
    logic [31:0] rdd[2], idv[2], tsv[2];
    logic [31:0] s_id = DEF_EXPECTED_ID, s_ts = DEF_EXPECTED_TS;
    int s_wid = 0, s_wts = 0;
    bit s_sid = 0, s_sts = 0;
    int cyc = 0, ncmp = 0, nerr = 0;
    exp_t q0[$], q1[$];
    logic [31:0] last_id[2] = '{0, 0}, last_ts[2] = '{0, 0};
    bit pdone[2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: latency 0, timestamp enforced, timeout 4; instance 1: latency 2, timestamp ignored, timeout 6
    for (genvar g = 0; g < 2; g++) begin : u
        int wcnt, pend;
        logic paddr;
        soc_system_sysid_checker #(
            .CHECK_TS(g == 0), .READ_LATENCY(g == 0 ? 0 : 2), .TIMEOUT_CYCLES(g == 0 ? 4 : 6)
        ) dut (
            .clock(clk), .reset(rst), .start(start), .avm_address(adr[g]), .avm_read(rd[g]),
            .avm_readdata(rdd[g]), .avm_waitrequest(wr[g]), .busy(busy[g]), .done(done[g]),
            .id_ok(id_ok[g]), .ts_ok(ts_ok[g]), .pass(pass[g]), .timeout(tmo[g]),
            .id_value(idv[g]), .ts_value(tsv[g])
        );
        assign wr[g] = rd[g] && ((adr[g] ? s_sts : s_sid) || wcnt < (adr[g] ? s_wts : s_wid));
        assign rdd[g] = g == 0 ? (rd[g] ? (adr[g] ? s_ts : s_id) : 32'hDEAD_BEEF)
                               : (pend == 1 ? (paddr ? s_ts : s_id) : 32'hDEAD_BEEF);
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                wcnt <= 0;
                pend <= 0;
                paddr <= 1'b0;
            end else begin
                wcnt <= (rd[g] && wr[g]) ? wcnt + 1 : 0;
                pend <= (rd[g] && !wr[g]) ? 2 : (pend > 0 ? pend - 1 : 0);
                if (rd[g] && !wr[g]) paddr <= adr[g];
            end
        end
    end

    function automatic exp_t model(int i, int base);
        exp_t e;
        int lat = i == 0 ? 0 : 2;
        int t = i == 0 ? 4 : 6;
        bit chk = i == 0;
        e.tmo = s_sid || s_sts;
        e.id = s_sid ? last_id[i] : s_id;
        e.ts = e.tmo ? last_ts[i] : s_ts;
        e.cyc = base + (s_sid ? t : s_wid + 1 + lat + (s_sts ? t : s_wts + 1 + lat));
        e.id_ok = !e.tmo && e.id == DEF_EXPECTED_ID;
        e.ts_ok = !e.tmo && e.ts == DEF_EXPECTED_TS;
        e.pass = e.id_ok && (e.ts_ok || !chk);
        return e;
    endfunction

    task automatic expect_check(int base);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = model(i, base);
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
            last_id[i] = e.id;
            last_ts[i] = e.ts;
        end
    endtask

    task automatic chk(string nm, int i, logic [95:0] act, logic [95:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h, required %h", nm, i, act, req);
        end
    endtask

    // Monitor: reset values while in reset, verdict on each rising done, busy/done consistency otherwise
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk("reset_status", i, {rd[i], adr[i], busy[i], done[i], id_ok[i], ts_ok[i], pass[i], tmo[i]}, 8'b0010_0000);
                chk("reset_values", i, {idv[i], tsv[i]}, 64'd0);
            end else if (done[i] && !pdone[i]) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_done dut%0d: done rose at cycle %0d, required no result pending", i, cyc);
                end else begin
                    exp_t e;
                    e = i == 0 ? q0.pop_front() : q1.pop_front();
                    chk("done_cycle", i, cyc, e.cyc);
                    chk("status", i, {rd[i], busy[i], id_ok[i], ts_ok[i], pass[i], tmo[i]},
                        {2'b00, e.id_ok, e.ts_ok, e.pass, e.tmo});
                    chk("values", i, {idv[i], tsv[i]}, {e.id, e.ts});
                end
            end else begin
                chk("busy_vs_done", i, busy[i], !done[i]);
            end
            pdone[i] = rst ? 1'b0 : done[i];
        end
    end

    task automatic set_scn(logic [31:0] id, logic [31:0] ts, int wid, int wts, bit sid, bit sts);
        s_id = id;
        s_ts = ts;
        s_wid = wid;
        s_wts = wts;
        s_sid = sid;
        s_sts = sts;
    endtask

    task automatic rand_scn();
        logic [31:0] v[2];
        for (int k = 0; k < 2; k++) begin
            int r = $urandom_range(0, 3);
            logic [31:0] base = k == 0 ? DEF_EXPECTED_ID : DEF_EXPECTED_TS;
            v[k] = r < 2 ? base : r == 2 ? base ^ (32'd1 << $urandom_range(0, 31)) : 32'($urandom);
        end
        set_scn(v[0], v[1], $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        if ($urandom_range(0, 9) == 0) s_sid = 1;
        else if ($urandom_range(0, 9) == 0) s_sts = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            $display("FAIL hang: done never rose, pending %0d/%0d, required 0/0", q0.size(), q1.size());
            $fatal(1);
        end
        @(negedge clk);
    endtask

    task automatic launch(bit poke);
        @(negedge clk);
        start = 1'b1;
        expect_check(cyc + 1);
        @(negedge clk);
        start = poke;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic recheck(bit poke);
        launch(poke);
        wait_idle();
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        q0.delete();
        q1.delete();
        last_id = '{0, 0};
        last_ts = '{0, 0};
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_check(cyc + 1);
        wait_idle();
    endtask

    initial begin
        release_reset();
        set_scn(32'hACD5_1303, DEF_EXPECTED_TS, 0, 0, 0, 0);
        recheck(0);
        set_scn(DEF_EXPECTED_ID, 32'h0, 1, 0, 0, 0);
        recheck(1);
        set_scn(DEF_EXPECTED_ID, DEF_EXPECTED_TS, 0, 0, 1, 0);
        recheck(0);
        set_scn(DEF_EXPECTED_ID, DEF_EXPECTED_TS, 0, 0, 0, 0);
        recheck(0);
        set_scn(DEF_EXPECTED_ID, DEF_EXPECTED_TS, 3, 0, 0, 0);
        recheck(0);
        set_scn(DEF_EXPECTED_ID, DEF_EXPECTED_TS, 0, 0, 0, 1);
        recheck(0);
        set_scn(DEF_EXPECTED_ID, DEF_EXPECTED_TS, 0, 0, 0, 0);
        launch(0);
        repeat (3) @(negedge clk);
        assert_reset();
        release_reset();
        for (int n = 0; n < 40; n++) begin
            rand_scn();
            if ($urandom_range(0, 5) == 0) begin
                launch($urandom_range(0, 1) == 1);
                repeat ($urandom_range(0, 8)) @(negedge clk);
                assert_reset();
                rand_scn();
                release_reset();
            end else begin
                recheck($urandom_range(0, 1) == 1);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/soc_system_sysid_checker.md
# soc_system_sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two read words. After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), compares them against expected constants, and publishes registered pass/fail/timeout status. Boot logic and status LEDs use the result to gate operation on a matching FPGA image.

## Interface
- EXPECTED_ID, 32'hACD5_1302, expected word at address 0
- EXPECTED_TS, 32'h5592_5416, expected word at address 1
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp is captured only
- READ_LATENCY, 0, fixed slave read latency in cycles (legal 0..3)
- TIMEOUT_CYCLES, 255, consecutive waitrequest cycles before a read is abandoned (legal 1..65535)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle recheck request
- avm_address  out  1  slave word select
- avm_read  out  1  read strobe
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall; tie 0 for the ID slave
- busy  out  1  check in progress
- done  out  1  result valid; held until next check starts
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TS
- pass  out  1  done & id_ok & (ts_ok | !CHECK_TS) & !timeout
- timeout  out  1  a read exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE: entered on reset; unconditionally moves to RD_ID on the next edge (auto-check after reset).
- RD_ID: avm_read=1, avm_address=0. On an edge with !waitrequest, the read is accepted. If READ_LATENCY=0, avm_readdata is captured into id_value and the FSM moves to RD_TS. Otherwise it moves to LAT_ID.
- LAT_ID: avm_read=0. A latency counter captures avm_readdata on the READ_LATENCY-th edge after acceptance, then moves to RD_TS.
- RD_TS and LAT_TS: same behaviour with address 1. The final capture edge also registers id_ok, ts_ok, pass and done=1, then moves to DONE.
- DONE: avm_read=0. start moves to RD_ID and clears done, id_ok, ts_ok, pass and timeout on that edge. id_value and ts_value keep their old contents until overwritten.
- start outside DONE or IDLE is ignored (no queuing).
- Timeout: a 16-bit counter clears on entry to RD_ID or RD_TS and increments on each cycle with read & waitrequest. When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with timeout=1, done=1, id_ok=0, ts_ok=0, pass=0, and read deasserted.
- avm_address is held stable for the whole read, including waitrequest cycles.
- busy = state is not DONE.

## Timing
- Reset values: all status outputs 0; id_value and ts_value 0; avm_read 0; avm_address 0; busy 1; state IDLE.
- With READ_LATENCY=0 and no stall: edge 1 after reset release enters RD_ID; edge 2 accepts ID; edge 3 accepts timestamp and sets done. done is visible 3 cycles after reset release.
- Each wait cycle adds 1 cycle. Each latency step adds READ_LATENCY cycles per word.
- Reset asserted mid-read: avm_read drops immediately (asynchronous) and the FSM returns to IDLE. The check restarts after release.
- start coinciding with reset: reset wins.
- All outputs are registered; no combinational path from Avalon inputs to status outputs.

## Structure
- Package soc_system_sysid_pkg holds the state enum, the default EXPECTED_ID and EXPECTED_TS constants, and the 16-bit timeout counter width.
- Single module, no sub-module. The latency counter and timeout counter are small enough to stay inline.

## Test plan
- Slave model returns 32'hACD5_1302 / 32'h5592_5416, latency 0, no wait -> done at cycle 3, pass=1, id_ok=1, ts_ok=1.
- Slave returns ID 32'hACD5_1303 -> done=1, id_ok=0, pass=0, and id_value=32'hACD5_1303.
- Timestamp 32'h0 with CHECK_TS=0 -> pass=1, ts_ok=0. Same stimulus with CHECK_TS=1 -> pass=0.
- waitrequest held high, TIMEOUT_CYCLES=4 -> timeout=1 after 4 stall cycles, avm_read=0, pass=0. A later start with waitrequest=0 -> pass=1 and timeout cleared.
- READ_LATENCY=2, 3 wait cycles on the ID read -> correct capture, and done at cycle 3+3+2+2=10.
- Reset asserted while in LAT_TS, then released -> avm_read=0 immediately, status cleared, full recheck completes with pass=1.
